alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Multi-cycle execute sequencer that sits directly upstream of the 16-bit ALU. It accepts one instruction per handshake and reads operands from an internal 8x16 register file. It drives the ALU's 3-bit select and two 16-bit operands from registered latches, captures the ALU result and writes it back to the destination register. It is the operand-fetch and writeback stage of the Bitty datapath.

Parameters:
DATA_W, 16, datapath width; only 16 is supported. Must match the ALU.
REG_RESET, 16'h0000, value loaded into every register-file entry on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr_ready  output  1  controller can accept an instruction (high only in IDLE)
instr  input  16  [15:13] rx, [12:10] ry, [12:5] imm8 (fmt 01 only), [4:2] alu_sel, [1:0] fmt
alu_select  output  3  to ALU select
alu_in_a  output  16  to ALU operand A
alu_in_b  output  16  to ALU operand B
alu_res  input  16  combinational result from ALU
done  output  1  one-cycle pulse: instruction retired
err  output  1  high with done when fmt was illegal
init_we  input  1  register-file load strobe (test/boot)
init_addr  input  3  register-file load address
init_data  input  16  register-file load data
dbg_addr  input  3  debug read address
dbg_data  output  16  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all regfile entries=REG_RESET; latches A, B, sel, res, rx, fmt = 0. alu_select/alu_in_a/alu_in_b=0, done=0, err=0. Reset mid-instruction aborts it; no writeback occurs.
- Outputs alu_select, alu_in_a and alu_in_b always reflect internal latches, never instr directly.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr fields and go to LOAD_A.
  - LOAD_A: A <= regfile[rx]. Go to LOAD_B.
  - LOAD_B: fmt 00: B <= regfile[ry]. fmt 01: B <= {8'h00, imm8}. sel latch drives alu_select. Go to EXEC.
  - EXEC: ALU inputs stable. res <= alu_res at end of cycle. Go to WB.
  - WB: done=1. If fmt is 00 or 01, regfile[rx] <= res at end of cycle. If fmt is 10 or 11, err=1 and no write. Go to IDLE.
- Latency: the accept edge is E0. done is high in the cycle after edge E3. The register is updated at E4. Next accept is possible in the IDLE cycle following WB, giving 1 instruction per 5 cycles max.
- done and err are Moore outputs of WB. They are low in every other state.
- Arithmetic: all 16-bit, modulo 2^16. No carry/overflow is kept. CMP result (0/1/2) is written to rx like any other op.
- rx==ry is legal. Both operands read the same, pre-instruction value.
- init_we is honoured only in IDLE and ignored in other states. Accept and init_we in the same IDLE cycle: the init write lands at that edge, and LOAD_A/LOAD_B read the updated value.
- instr is sampled only at the accept edge. Changes afterwards are ignored. instr_valid while busy is held off (ready=0), not dropped.
- dbg_data is combinational from the array. The written value is visible the cycle after the write edge.

Test Plan:
- Reset, init R1=5, R2=3, send 0x2800 (ADD R1,R2) -> instr_ready low 4 cycles, done at accept+4, err=0, dbg R1=0x0008, R2=0x0003.
- Init R3=0x0010, send 0x61E5 (SUB R3, imm 0x0F) -> alu_select=001, alu_in_b=0x000F in EXEC; R3=0x0001.
- Init R4=2, R5=7, send 0x941C (CMP R4,R5) -> R4=0x0002. Repeat with R4=9 -> R4=0x0001.
- Init R6=0xFFFF, R7=1, ADD R6,R7 -> R6=0x0000 (wrap). Send 0x2802 (fmt 10) -> done and err high for one cycle, R1 unchanged.
- Hold instr_valid high with back-to-back instructions -> one accepted per 5 cycles; instr changed mid-op has no effect. init_we in EXEC is ignored.
- Assert reset during EXEC -> next cycle IDLE, done=0, all registers 0, instr_ready=1.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: operand-fetch / writeback sequencer in front of a 16-bit ALU.
// Accepts one instruction per handshake, reads operands from an internal 8x16
// register file, drives the ALU from registered latches, captures the ALU
// result and writes it back to rx. One instruction retires every 5 cycles.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   instr_valid/instr_ready - instruction handshake (ready only in IDLE)
//   instr[15:0]             - [15:13] rx, [12:10] ry, [12:5] imm8, [4:2] sel, [1:0] fmt
//   alu_select/alu_in_a/b   - registered ALU controls and operands
//   alu_res                 - combinational ALU result
//   done, err               - one-cycle retire pulse, illegal-format flag
//   init_we/addr/data       - register-file load port (honoured in IDLE only)
//   dbg_addr/dbg_data       - combinational register-file read port
module alu_exec_ctrl #(
    parameter int                 DATA_W    = 16,
    parameter logic [DATA_W-1:0]  REG_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [2:0]        alu_select,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    input  logic [DATA_W-1:0] alu_res,
    output logic              done,
    output logic              err,
    input  logic              init_we,
    input  logic [2:0]        init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic              accept_s;

    logic [DATA_W-1:0] rf_r [0:7];
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] res_r;
    logic [2:0]        sel_r;
    logic [2:0]        rx_r;
    logic [2:0]        ry_r;
    logic [7:0]        imm_r;
    logic [1:0]        fmt_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;

    assign accept_s = (state_r == ST_IDLE) && instr_valid;

    // Next-state logic for the five-step execute sequence
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nx_s = ST_LOAD_A;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD_A: state_nx_s = ST_LOAD_B;
            ST_LOAD_B: state_nx_s = ST_EXEC;
            ST_EXEC:   state_nx_s = ST_WB;
            ST_WB:     state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State register plus registered Moore outputs (ready/done/err)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == ST_IDLE);
            done_r  <= (state_nx_s == ST_WB);
            // fmt 10/11 are illegal; fmt_r is stable from accept through WB
            err_r   <= (state_nx_s == ST_WB) && fmt_r[1];
        end
    end

    // Instruction latches, operand latches, result capture and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= REG_RESET;
            end
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            sel_r <= 3'd0;
            rx_r  <= 3'd0;
            ry_r  <= 3'd0;
            imm_r <= 8'd0;
            fmt_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // An init write on the accept edge lands before LOAD_A reads
                    if (init_we) begin
                        rf_r[init_addr] <= init_data;
                    end
                    if (accept_s) begin
                        rx_r  <= instr[15:13];
                        ry_r  <= instr[12:10];
                        imm_r <= instr[12:5];
                        sel_r <= instr[4:2];
                        fmt_r <= instr[1:0];
                    end
                end
                ST_LOAD_A: a_r <= rf_r[rx_r];
                ST_LOAD_B: begin
                    if (fmt_r == 2'b01) begin
                        b_r <= {{(DATA_W-8){1'b0}}, imm_r};
                    end else begin
                        b_r <= rf_r[ry_r];
                    end
                end
                ST_EXEC: res_r <= alu_res;
                ST_WB: begin
                    if (!fmt_r[1]) begin
                        rf_r[rx_r] <= res_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = ready_r;
    assign done        = done_r;
    assign err         = err_r;
    assign alu_select  = sel_r;
    assign alu_in_a    = a_r;
    assign alu_in_b    = b_r;
    assign dbg_data    = rf_r[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with an ALU stand-in and a scoreboard of
// expected retire results.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_select;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [15:0] alu_res;
    logic        done;
    logic        err;
    logic        init_we;
    logic [2:0]  init_addr;
    logic [15:0] init_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    typedef struct {
        logic        err;
        logic [2:0]  rx;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_e;
    logic [15:0] model_rf [0:7];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 CMP
    function automatic logic [15:0] model_alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << 1;
            3'd6: return a >> 1;
            default: return (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
        endcase
    endfunction

    assign alu_res = model_alu(alu_select, alu_in_a, alu_in_b);

    alu_exec_ctrl #(.DATA_W(16), .REG_RESET(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_select(alu_select), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_res(alu_res), .done(done), .err(err),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic init_reg(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] v;
        init_we = 1'b1; init_addr = a; init_data = d;
        @(negedge clk);
        init_we = 1'b0;
        model_rf[a] = d;
        rd(a, v);
        chk("init_visible", v, d);
    endtask

    // Predict and push the result, then run one instruction to retirement.
    task automatic run_instr(input logic [15:0] ins, input logic acc_init, input logic [2:0] ia,
                             input logic [15:0] idat, input logic exec_init);
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] v;
        logic        seen;
        if (acc_init) begin
            init_we = 1'b1; init_addr = ia; init_data = idat;
            model_rf[ia] = idat;
        end
        a = model_rf[ins[15:13]];
        b = (ins[1:0] == 2'b01) ? {8'h00, ins[12:5]} : model_rf[ins[12:10]];
        e.err = ins[1];
        e.rx  = ins[15:13];
        e.val = model_alu(ins[4:2], a, b);
        sb.push_back(e);
        if (!e.err) model_rf[e.rx] = e.val;
        chk("ready_idle", {15'd0, instr_ready}, 16'd1);
        instr_valid = 1'b1;
        instr       = ins;
        seen        = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            init_we     = 1'b0;
            instr_valid = 1'b0;
            instr       = ~ins;
            if (c < 4) chk("busy_ready", {15'd0, instr_ready}, 16'd0);
            if (c == 3) begin
                chk("exec_sel", {13'd0, alu_select}, {13'd0, ins[4:2]});
                chk("exec_a", alu_in_a, a);
                chk("exec_b", alu_in_b, b);
                if (exec_init) begin
                    init_we = 1'b1; init_addr = 3'd0; init_data = 16'hBEEF;
                end
            end
            if (done) begin
                chk("latency", 16'(c), 16'd4);
                if (sb.size() == 0) begin
                    chk("sb_empty", 16'd1, 16'd0);
                end else begin
                    last_e = sb.pop_front();
                    chk("err_flag", {15'd0, err}, {15'd0, last_e.err});
                end
                seen = 1'b1;
            end
        end
        if (!seen) chk("done_timeout", 16'd0, 16'd1);
        @(negedge clk);
        init_we = 1'b0;
        chk("done_pulse", {15'd0, done}, 16'd0);
        chk("err_pulse", {15'd0, err}, 16'd0);
        chk("ready_back", {15'd0, instr_ready}, 16'd1);
        rd(last_e.rx, v);
        chk("wb_val", v, model_rf[last_e.rx]);
    endtask

    initial begin
        logic [15:0] v;
        int          n_acc;
        int          n_done;
        int          acc_c [0:1];
        int          done_c [0:1];

        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        init_we = 1'b0; init_addr = 3'd0; init_data = 16'h0000; dbg_addr = 3'd0;
        for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_sel", {13'd0, alu_select}, 16'd0);
        chk("rst_a", alu_in_a, 16'd0);
        chk("rst_b", alu_in_b, 16'd0);

        // ADD R1,R2
        init_reg(3'd1, 16'h0005);
        init_reg(3'd2, 16'h0003);
        run_instr(16'h2800, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd1, v); chk("add_r1", v, 16'h0008);
        rd(3'd2, v); chk("add_r2", v, 16'h0003);

        // SUB R3, imm 0x0F
        init_reg(3'd3, 16'h0010);
        run_instr(16'h61E5, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd3, v); chk("sub_imm_r3", v, 16'h0001);

        // CMP R4,R5 less-than then greater-than
        init_reg(3'd4, 16'h0002);
        init_reg(3'd5, 16'h0007);
        run_instr(16'h941C, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd4, v); chk("cmp_lt", v, 16'h0002);
        init_reg(3'd4, 16'h0009);
        run_instr(16'h941C, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd4, v); chk("cmp_gt", v, 16'h0001);

        // ADD wrap-around
        init_reg(3'd6, 16'hFFFF);
        init_reg(3'd7, 16'h0001);
        run_instr(16'hDC00, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd6, v); chk("add_wrap", v, 16'h0000);

        // Illegal fmt 10: err, no write
        run_instr(16'h2802, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd1, v); chk("illegal_nowrite", v, 16'h0008);

        // rx == ry: ADD R2,R2
        run_instr(16'h4800, 1'b0, 3'd0, 16'h0, 1'b0);
        rd(3'd2, v); chk("same_reg", v, 16'h0006);

        // init write on the accept edge is seen by operand fetch
        run_instr(16'h2800, 1'b1, 3'd1, 16'h0100, 1'b0);
        rd(3'd1, v); chk("accept_init", v, 16'h0106);

        // init write during EXEC is ignored
        run_instr(16'h2800, 1'b0, 3'd0, 16'h0, 1'b1);
        rd(3'd1, v); chk("exec_init_r1", v, 16'h010C);
        rd(3'd0, v); chk("exec_init_r0", v, 16'h0000);

        // Back-to-back with instr_valid held; instr changes mid-op
        last_e.err = 1'b0; last_e.rx = 3'd1; last_e.val = model_rf[1] + model_rf[2];
        sb.push_back(last_e); model_rf[1] = last_e.val;
        last_e.rx = 3'd3; last_e.val = model_rf[3] - 16'h000F;
        sb.push_back(last_e); model_rf[3] = last_e.val;
        n_acc = 0; n_done = 0;
        instr_valid = 1'b1; instr = 16'h2800;
        for (int c = 0; c < 20 && n_done < 2; c++) begin
            if (instr_ready && instr_valid && n_acc < 2) begin acc_c[n_acc] = c; n_acc++; end
            @(negedge clk);
            if (n_acc == 1) instr = 16'h61E5;
            if (n_acc == 2) instr_valid = 1'b0;
            if (done && n_done < 2) begin
                done_c[n_done] = c;
                n_done++;
                if (sb.size() == 0) begin
                    chk("b2b_sb_empty", 16'd1, 16'd0);
                end else begin
                    last_e = sb.pop_front();
                    chk("b2b_err", {15'd0, err}, {15'd0, last_e.err});
                end
            end
        end
        instr_valid = 1'b0;
        chk("b2b_done_cnt", 16'(n_done), 16'd2);
        chk("b2b_acc_cnt", 16'(n_acc), 16'd2);
        if (n_acc == 2) chk("b2b_acc_gap", 16'(acc_c[1] - acc_c[0]), 16'd5);
        if (n_done == 2) chk("b2b_done_gap", 16'(done_c[1] - done_c[0]), 16'd5);
        @(negedge clk);
        rd(3'd1, v); chk("b2b_r1", v, 16'h0112);
        rd(3'd3, v); chk("b2b_r3", v, 16'hFFF2);

        // Reset during EXEC aborts with no writeback
        instr_valid = 1'b1; instr = 16'h2800;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {15'd0, instr_ready}, 16'd1);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_sel", {13'd0, alu_select}, 16'd0);
        chk("abort_a", alu_in_a, 16'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk("abort_reg", v, 16'h0000);
        end
        v = 16'd0;
        repeat (6) begin
            @(negedge clk);
            if (done) v = v + 16'd1;
        end
        chk("abort_no_done", v, 16'd0);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
